// File: rtl/salu_instr_pkg.sv
// Shared types and helpers for the scalar-ALU instruction fetch path.
// Instruction beats are 64 bits: an opcode dword plus an optional literal dword.
package salu_instr_pkg;

  localparam int INSTR_SIZE = 64;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  // A literal follows the opcode dword when the encoding class is 2'b10 and
  // either of the two low source-operand fields selects the literal slot (8'hFF).
  function automatic logic instr_has_literal(input logic [31:0] dw);
    return ((dw & 32'hC000_0000) == 32'h8000_0000) &&
           (((dw & 32'h0000_00FF) == 32'h0000_00FF) ||
            ((dw & 32'h0000_FF00) == 32'h0000_FF00));
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Valid/ready stream carrying decoded-width instruction beats to the decoder.
interface decoupled_intr #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/instr_dword_fifo.sv
// Dword FIFO with single push and 1-or-2 dword pop; exposes the two head entries
// so a literal instruction can be assembled without waiting an extra cycle.
module instr_dword_fifo #(
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop1,
  input  logic          pop2,
  output logic [31:0]   head0,
  output logic [31:0]   head1,
  output logic [CW-1:0] count
);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [1:0]    pop_n;

  assign pop_n = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PW'(1)];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally; DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push) - CW'(pop_n);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues in-order dword reads, buffers returns, and emits
// 32- or 64-bit instruction beats; redirect/stop flush and drop in-flight returns.
module instr_fetch
  import salu_instr_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stop,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  decoupled_intr.master         instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] fetch_pc, sel_pc;
  logic [CW-1:0]         outstanding, stale_count, fifo_count, out_next;
  logic [CW:0]           occupancy;
  logic                  in_run, req_hs, rsp_drop, do_start, do_redirect, reload;
  logic                  push, pop, has_lit;
  logic [31:0]           head0, head1;

  assign in_run      = (state == FETCH_RUN);
  assign req_hs      = mem_req_valid && mem_req_ready;
  assign rsp_drop    = mem_rsp_valid && (stale_count != '0);
  assign do_redirect = !stop && in_run && (redirect_valid || start_valid);
  assign do_start    = !stop && !in_run && start_valid;
  assign reload      = stop || do_redirect || do_start;
  assign sel_pc      = redirect_valid ? redirect_pc : start_pc;
  assign out_next    = outstanding + CW'(req_hs) - CW'(mem_rsp_valid);

  // Occupancy counts in-flight reads, so every return is guaranteed a slot.
  assign occupancy     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_req_valid = in_run && (outstanding < CW'(MAX_OUTSTANDING)) &&
                         (occupancy < (CW+1)'(FIFO_DEPTH));
  assign mem_req_addr  = fetch_pc;

  assign push = mem_rsp_valid && (stale_count == '0) && !reload;

  assign has_lit     = instr_has_literal(head0);
  assign instr.valid = has_lit ? (fifo_count >= CW'(2)) : (fifo_count != '0);
  assign instr.data  = !instr.valid ? '0 :
                       has_lit      ? {head1, head0} : {32'h0, head0};
  assign pop         = instr.valid && instr.ready;

  instr_dword_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (reload),
    .push      (push),
    .push_data (mem_rsp_data),
    .pop1      (pop && !has_lit),
    .pop2      (pop && has_lit),
    .head0     (head0),
    .head1     (head1),
    .count     (fifo_count)
  );

  // Every read still in flight after a reload belongs to the old stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_IDLE;
      fetch_pc    <= '0;
      outstanding <= '0;
      stale_count <= '0;
    end else begin
      outstanding <= out_next;
      if (reload)        stale_count <= out_next;
      else if (rsp_drop) stale_count <= stale_count - CW'(1);

      if (stop) begin
        state <= FETCH_IDLE;
      end else if (do_redirect || do_start) begin
        state    <= FETCH_RUN;
        fetch_pc <= sel_pc & ~ADDR_WIDTH'(3);
      end else if (req_hs) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
    end
  end

endmodule
